// File: rtl/cpuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpuf_pkg                                                   |
// | Shared constants, loader state encoding and CPU opcodes for the      |
// | 4-bit-address CPU and its program loader.                            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cpuf_pkg;

  // RAM geometry of the CPU program store
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  // CPU opcodes (upper nibble of an instruction byte)
  localparam logic [3:0] LDA = 4'b1000;
  localparam logic [3:0] LDB = 4'b0100;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] JMP = 4'b1001;
  localparam logic [3:0] HLT = 4'b1111;

  // Loader state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/prog_csum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : prog_csum                                                  |
// | Running modulo-2^W byte sum with clear and add-enable. The zero      |
// | flag reports whether sum + operand wraps to zero, which lets the     |
// | checksum byte be validated in the same cycle it arrives.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module prog_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] operand,
  output logic         zero
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;
  logic [W-1:0] sum_plus;

  // Next-sum selection: clear has priority over accumulate
  always_comb begin
    sum_plus = sum_q + operand;
    sum_d    = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_plus;
    end
  end

  assign zero = (sum_plus == '0);

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : prog_loader                                                |
// | Framed byte-stream program loader: LEN, N payload bytes, CSUM.       |
// | Writes payload into program RAM, holds the CPU in reset while        |
// | loading and releases it once the frame checksum verifies.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module prog_loader
  import cpuf_pkg::*;
#(
  parameter int ADDR_W = cpuf_pkg::ADDR_W,
  parameter int DATA_W = cpuf_pkg::DATA_W,
  parameter int DEPTH  = cpuf_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_inc;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              len_ok;
  logic              csum_clr;
  logic              csum_add;
  logic              csum_zero;

  // A byte moves only when the registered ready is high
  assign xfer   = in_valid && in_ready_q;
  assign len_ok = (in_data != '0) && (in_data <= DATA_W'(DEPTH));

  prog_csum #(
    .W (DATA_W)
  ) u_csum (
    .clk     (clk),
    .reset   (reset),
    .clr     (csum_clr),
    .add_en  (csum_add),
    .operand (in_data),
    .zero    (csum_zero)
  );

  // Next-state, counter, write-port and status computation
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    csum_clr  = 1'b0;
    csum_add  = 1'b0;
    count_inc = count_q + (ADDR_W + 1)'(1);

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          if (len_ok) begin
            len_d    = in_data[ADDR_W:0];
            count_d  = '0;
            csum_clr = 1'b1;
            state_d  = ST_DATA;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[ADDR_W-1:0];
          wr_data_d = in_data;
          csum_add  = 1'b1;
          // count stops at N, so it can never pass DEPTH
          if (count_q < len_q) begin
            count_d = count_inc;
          end
          if (count_inc >= len_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_d = csum_zero ? ST_RUN : ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they register
    // in step with the state change
    in_ready_d  = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    err_d       = (state_d == ST_ERR);
  end

  // State and output registers; reset overrides any same-cycle transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_prog_loader                                             |
// | Self-checking bench for prog_loader: table of frames plus a          |
// | hand-written mid-frame reset sequence; RAM writes are scoreboarded.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_prog_loader;
  import cpuf_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_reset;
  logic       done;
  logic       err;
  logic [4:0] count;

  prog_loader #(
    .ADDR_W (4),
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected RAM writes {addr, data}
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;

  // Every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr_data", 32'({wr_addr, wr_data}), 32'(mon_e));
      end
    end
  end

  typedef struct packed {
    logic [7:0]   len;
    logic [127:0] pay;
    logic [7:0]   csum;
    logic         gaps;
    logic         mid_start;
    logic         exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte, wait (bounded) for ready, optionally expect a write
  task automatic send_byte(input logic [7:0] b, input logic gaps, input logic push,
                           input logic [3:0] addr);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end
    if (push) exp_q.push_back({addr, b});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] good[8];
    logic [3:0] ops[6];
    logic [7:0] s;
    logic [7:0] b;
    logic       lv;
    vec_t       v;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    good = '{8'h04, 8'h86, 8'h47, 8'h21, 8'h98, 8'h0E, 8'h0C, 8'h88};
    ops  = '{LDA, LDB, ADD, SUB, JMP, HLT};

    vecs[0] = '0;
    vecs[0].len = 8'h08;
    for (int i = 0; i < 8; i++) vecs[0].pay[i*8 +: 8] = good[i];
    vecs[0].csum = 8'hD4;
    vecs[0].exp_done = 1'b1;

    vecs[1] = vecs[0];
    vecs[1].csum = 8'hD5;
    vecs[1].exp_done = 1'b0;

    vecs[2] = '0;
    vecs[2].len = 8'h00;

    vecs[3] = '0;
    vecs[3].len = 8'h11;

    vecs[4] = '0;
    vecs[4].len = 8'h10;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b = {ops[i % 6], 4'(15 - i)};
      vecs[4].pay[i*8 +: 8] = b;
      s = s + b;
    end
    vecs[4].csum = 8'h00 - s;
    vecs[4].exp_done = 1'b1;

    vecs[5] = '0;
    vecs[5].len = 8'h02;
    vecs[5].pay[7:0]  = 8'hAA;
    vecs[5].pay[15:8] = 8'h55;
    vecs[5].csum = 8'h01;
    vecs[5].gaps = 1'b1;
    vecs[5].mid_start = 1'b1;
    vecs[5].exp_done = 1'b1;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_wr_en",     32'(wr_en),     32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_count",     32'(count),     32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);

    for (int k = 0; k < 6; k++) begin
      v  = vecs[k];
      lv = (v.len != 8'h00) && (v.len <= 8'd16);
      pulse_start();
      check("start_in_ready",  32'(in_ready),  32'd1);
      check("start_cpu_reset", 32'(cpu_reset), 32'd1);
      check("start_done",      32'(done),      32'd0);
      check("start_err",       32'(err),       32'd0);
      send_byte(v.len, v.gaps, 1'b0, 4'h0);
      if (!lv) begin
        check("badlen_err",      32'(err),       32'd1);
        check("badlen_in_ready", 32'(in_ready),  32'd0);
        check("badlen_wr_en",    32'(wr_en),     32'd0);
        check("badlen_cpu_rst",  32'(cpu_reset), 32'd1);
      end else begin
        for (int i = 0; i < int'(v.len); i++) begin
          if (v.mid_start && i == 0) start = 1'b1;
          send_byte(v.pay[i*8 +: 8], v.gaps, 1'b1, 4'(i));
          start = 1'b0;
          check("wr_latency", 32'(wr_en), 32'd1);
          check("data_count", 32'(count), 32'(i + 1));
          check("data_in_ready", 32'(in_ready), 32'd1);
        end
        send_byte(v.csum, v.gaps, 1'b0, 4'h0);
        check("end_done",      32'(done),      32'(v.exp_done));
        check("end_err",       32'(err),       32'(!v.exp_done));
        check("end_cpu_reset", 32'(cpu_reset), 32'(!v.exp_done));
        check("end_in_ready",  32'(in_ready),  32'd0);
        check("end_count",     32'(count),     32'(v.len));
      end
      repeat (2) @(posedge clk);
      #1;
      check("writes_drained", 32'(exp_q.size()), 32'd0);
    end

    // Reset in the same cycle as the 3rd payload transfer
    pulse_start();
    send_byte(8'h04, 1'b0, 1'b0, 4'h0);
    send_byte(8'h11, 1'b0, 1'b1, 4'h0);
    send_byte(8'h22, 1'b0, 1'b1, 4'h1);
    in_valid = 1'b1;
    in_data  = 8'h33;
    reset    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    check("midrst_wr_en",     32'(wr_en),     32'd0);
    check("midrst_wr_addr",   32'(wr_addr),   32'd0);
    check("midrst_wr_data",   32'(wr_data),   32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_done",      32'(done),      32'd0);
    check("midrst_err",       32'(err),       32'd0);
    check("midrst_count",     32'(count),     32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_idle_ready", 32'(in_ready), 32'd0);
    check("midrst_drained",    32'(exp_q.size()), 32'd0);
    pulse_start();
    check("midrst_restart_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the 4-bit-address CPU. It accepts a framed program image over a valid/ready byte interface and writes it into program RAM through a dedicated write port. It holds the CPU in reset while loading, then releases it once the frame checksum verifies. It is the writer for the instruction-fetch path and sits between the host link and the RAM write port.

## Interface

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word and stream byte width.
- DEPTH, 16, number of RAM words; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load from IDLE, RUN or ERR.
- in_valid  in  1  stream byte present.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- cpu_reset  out  1  holds the CPU in reset; high in every state except RUN.
- done  out  1  load verified; high only in RUN.
- err  out  1  load failed; high only in ERR.
- count  out  ADDR_W+1  payload bytes written in the current frame.

## Operation

- Frame format: LEN byte (N), then N payload bytes, then one CSUM byte.
- Valid N is 1..DEPTH. A frame is good when (sum of payload + CSUM) mod 256 = 0.
- A byte transfers on a rising clk edge with in_valid && in_ready. in_valid while in_ready=0 has no effect.
- States: IDLE, LEN, DATA, CSUM, RUN, ERR.
- IDLE: in_ready=0. start moves to LEN.
- LEN: in_ready=1. On a transfer:
  - if N is 1..DEPTH, latch N, clear count and the running sum, go to DATA;
  - otherwise go to ERR with no writes.
- DATA: in_ready=1. Each transfer schedules a write of the byte to address count, adds it to the running sum, and increments count. The N-th transfer goes to CSUM.
- CSUM: in_ready=1. On a transfer, if (sum + byte) mod 256 = 0 go to RUN, else go to ERR.
- RUN / ERR: in_ready=0. start restarts at LEN.
- start is ignored in LEN, DATA and CSUM.
- Sum arithmetic: 8-bit, wraps modulo 256.
- count saturates at N and never exceeds DEPTH.
- Payload writes are not rolled back on a checksum failure. RAM contents after ERR are undefined for use; cpu_reset stays high.
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, done=0, err=0, count=0.
- Reset mid-frame: abort to IDLE. No write strobe follows, even if a byte transferred in the same cycle as reset (reset wins).

## Timing

- All outputs are registered.
- Write latency: a DATA byte accepted at edge k drives wr_en=1 with wr_addr/wr_data for the cycle after edge k, i.e. one cycle.
- Throughput: one byte per cycle. in_ready stays high continuously through LEN, DATA and CSUM.
- RUN entry: done=1 and cpu_reset=0 in the cycle after the CSUM transfer edge. The last payload write (issued earlier) is complete before cpu_reset falls.
- ERR entry: err=1 in the cycle after the offending LEN or CSUM transfer.
- Restart from RUN: start sampled at edge k gives cpu_reset=1, done=0, in_ready=1 after edge k.
- Restart from ERR: start sampled at edge k gives err=0, in_ready=1 after edge k.
- Minimum frame time for N payload bytes: N+2 transfer cycles plus 1 cycle to RUN.

## Structure

- Shared package cpuf_pkg holds:
  - the loader state enum;
  - ADDR_W, DATA_W and DEPTH constants;
  - the CPU opcode constants (LDA 4'b1000, LDB 4'b0100, ADD 4'b0010, SUB 4'b0001, JMP 4'b1001, HLT 4'b1111), used by the bench to build images.
- One sub-module: prog_csum, an 8-bit running-sum accumulator with clear, add-enable, and a zero-check of sum + operand.
- The FSM, counter and write register live in prog_loader.

## Test plan

- Good load: start, then LEN=0x08, payload 0x04 0x86 0x47 0x21 0x98 0x0E 0x0C 0x88, CSUM=0xD4 -> 8 writes to addresses 0..7 with the matching data, then done=1, cpu_reset=0, count=8.
- Bad checksum: same frame with CSUM=0xD5 -> all 8 writes occur, then err=1, cpu_reset=1, done=0; start restarts at LEN with in_ready=1.
- Bad length: LEN=0x00, and separately LEN=0x11 -> err=1 the next cycle with no wr_en pulse. LEN=0x10 with 16 payload bytes -> addresses 0..15 written, count=16.
- Backpressure and gaps: in_valid toggled randomly with LEN=0x02, payload 0xAA 0x55, CSUM=0x01 -> writes only on transfers, done=1. start pulsed mid-DATA -> ignored.
- Reset mid-frame: reset asserted in the same cycle as the 3rd payload transfer -> no write to address 2, state IDLE, all outputs at reset values, cpu_reset=1.
